// File: rtl/counter_responder_pkg.sv
// Shared types and constants for the counter responder: operation codes,
// FSM states and the width of the latency timer.
package counter_responder_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUSY     = 2'b01,
    WAIT_REL = 2'b10
  } state_e;

endpackage

// File: rtl/resp_delay_timer.sv
// Loadable down-counter that times the busy phase of the responder.
// load_i has priority over dec_i; zero_o flags a count of zero.
module resp_delay_timer
  import counter_responder_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic [TIMER_W-1:0] value_o,
  output logic               zero_o
);

  logic [TIMER_W-1:0] value_q;
  logic [TIMER_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i) begin
      value_d = value_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/counter_responder.sv
// Req/busy responder applying INC/DEC/CLR/LOAD to a counter after LATENCY cycles.
// Optional sticky protocol-error flag err_o when COUNTER_RESPONDER_ERR_EN is defined.
module counter_responder
  import counter_responder_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] counter_o
`ifdef COUNTER_RESPONDER_ERR_EN
  ,
  output logic             err_o
`endif
);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LATENCY - 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   counter_q, counter_d;
  logic               done_q, done_d;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_value;

  resp_delay_timer u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (TIMER_LOAD),
    .dec_i      (tmr_dec),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    counter_d = counter_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          op_d     = op_e'(op_i);
          data_d   = data_i;
          tmr_load = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (tmr_zero) begin
          case (op_q)
            OP_INC:  counter_d = counter_q + WIDTH'(1);
            OP_DEC:  counter_d = counter_q - WIDTH'(1);
            OP_CLR:  counter_d = '0;
            OP_LOAD: counter_d = data_q;
            default: counter_d = counter_q;
          endcase
          done_d  = 1'b1;
          // A still-high request must be released before the next accept.
          state_d = req_i ? WAIT_REL : IDLE;
        end else begin
          tmr_dec = |tmr_value;
        end
      end
      WAIT_REL: begin
        if (!req_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= OP_INC;
      data_q    <= '0;
      counter_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      counter_q <= counter_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = (state_q == BUSY);
  assign done_o    = done_q;
  assign counter_o = counter_q;

`ifdef COUNTER_RESPONDER_ERR_EN
  logic err_q, err_d;

  // Flags an early request drop or an op change while the operation is pending.
  always_comb begin
    err_d = err_q;
    if (state_q == BUSY && (!req_i || (op_e'(op_i) != op_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_counter_responder.sv
// Directed self-checking bench: LATENCY=3 main instance plus a LATENCY=1
// instance for back-to-back requests.
module tb_counter_responder;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [1:0] op;
  logic [3:0] data;
  logic       busy;
  logic       done;
  logic [3:0] counter;
  logic       req1;
  logic       busy1;
  logic       done1;
  logic [3:0] counter1;
`ifdef COUNTER_RESPONDER_ERR_EN
  logic       err;
  logic       err1;
`endif

  int checks   = 0;
  int failures = 0;

  counter_responder #(.WIDTH(4), .LATENCY(3)) u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .op_i      (op),
    .data_i    (data),
    .busy_o    (busy),
    .done_o    (done),
    .counter_o (counter)
`ifdef COUNTER_RESPONDER_ERR_EN
    ,
    .err_o     (err)
`endif
  );

  counter_responder #(.WIDTH(4), .LATENCY(1)) u_dut1 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req1),
    .op_i      (op),
    .data_i    (data),
    .busy_o    (busy1),
    .done_o    (done1),
    .counter_o (counter1)
`ifdef COUNTER_RESPONDER_ERR_EN
    ,
    .err_o     (err1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete request with a one-cycle req pulse, checking every cycle.
  task automatic do_op(input logic [1:0] o, input logic [3:0] d,
                       input logic [3:0] prev, input logic [3:0] exp, input string name);
    req = 1'b1; op = o; data = d;
    step();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || counter !== prev) begin
        failures++;
        $display("FAIL %s busy_phase cyc=%0d: busy=%b done=%b counter=%h, want busy=1 done=0 counter=%h",
                 name, i, busy, done, counter, prev);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || counter !== exp) begin
      failures++;
      $display("FAIL %s complete: busy=%b done=%b counter=%h, want busy=0 done=1 counter=%h",
               name, busy, done, counter, exp);
    end
    step();
    checks++;
    if (done !== 1'b0 || counter !== exp) begin
      failures++;
      $display("FAIL %s after: done=%b counter=%h, want done=0 counter=%h", name, done, counter, exp);
    end
    $display("txn %s op=%0d data=%h -> counter=%h", name, o, d, counter);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; req1 = 1'b0; op = 2'b00; data = 4'h0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || counter !== 4'h0 ||
        busy1 !== 1'b0 || done1 !== 1'b0 || counter1 !== 4'h0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b counter=%h busy1=%b done1=%b counter1=%h, want all 0",
               busy, done, counter, busy1, done1, counter1);
    end
`ifdef COUNTER_RESPONDER_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: err=%b, want 0", err);
    end
`endif
    rst_n = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_inc();
    do_op(2'b00, 4'h0, 4'h0, 4'h1, "inc_basic");
  endtask

  task automatic test_wrap();
    do_op(2'b11, 4'hF, 4'h1, 4'hF, "load_f");
    do_op(2'b00, 4'h0, 4'hF, 4'h0, "inc_wrap");
    do_op(2'b01, 4'h0, 4'h0, 4'hF, "dec_wrap");
  endtask

  task automatic test_held_req();
    int done_cnt = 0;
    int busy_cnt = 0;
    req = 1'b1; op = 2'b00; data = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (done_cnt != 1 || busy_cnt != 3 || counter !== 4'h0) begin
      failures++;
      $display("FAIL held_req: done_pulses=%0d busy_cycles=%0d counter=%h, want 1 3 0",
               done_cnt, busy_cnt, counter);
    end
    $display("txn held_req done_pulses=%0d busy_cycles=%0d counter=%h", done_cnt, busy_cnt, counter);
    req = 1'b0;
    step();
    do_op(2'b00, 4'h0, 4'h0, 4'h1, "inc_after_release");
  endtask

  task automatic test_op_change();
    req = 1'b1; op = 2'b00; data = 4'h0;
    step();
    op = 2'b10; data = 4'h7;
    step();
    step();
    step();
    checks++;
    if (counter !== 4'h2 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL op_change: counter=%h done=%b busy=%b, want counter=2 done=1 busy=0",
               counter, done, busy);
    end
    req = 1'b0; op = 2'b00;
    step();
`ifdef COUNTER_RESPONDER_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_set: err=%b, want 1", err);
    end
    step();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b, want 1", err);
    end
`endif
    $display("txn op_change counter=%h", counter);
  endtask

  task automatic test_abort();
    do_op(2'b11, 4'h3, 4'h2, 4'h3, "load_3");
    req = 1'b1; op = 2'b11; data = 4'h9;
    step();
    req = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (counter !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort: counter=%h busy=%b done=%b, want 0 0 0", counter, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (counter !== 4'h0 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet cyc=%0d: counter=%h done=%b busy=%b, want 0 0 0",
                 i, counter, done, busy);
      end
    end
    $display("txn abort counter=%h", counter);
    do_op(2'b00, 4'h0, 4'h0, 4'h1, "inc_after_abort");
  endtask

  task automatic test_back_to_back();
    op = 2'b00; data = 4'h0;
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || counter1 !== 4'h0) begin
      failures++;
      $display("FAIL b2b_busy1: busy=%b done=%b counter=%h, want 1 0 0", busy1, done1, counter1);
    end
    step();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b1 || counter1 !== 4'h1) begin
      failures++;
      $display("FAIL b2b_done1: busy=%b done=%b counter=%h, want 0 1 1", busy1, done1, counter1);
    end
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || counter1 !== 4'h1) begin
      failures++;
      $display("FAIL b2b_busy2: busy=%b done=%b counter=%h, want 1 0 1", busy1, done1, counter1);
    end
    step();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b1 || counter1 !== 4'h2) begin
      failures++;
      $display("FAIL b2b_done2: busy=%b done=%b counter=%h, want 0 1 2", busy1, done1, counter1);
    end
    step();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || counter1 !== 4'h2) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b done=%b counter=%h, want 0 0 2", busy1, done1, counter1);
    end
    $display("txn back_to_back counter1=%h", counter1);
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_held_req();
    test_op_change();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
